// File: rtl/seal_pkg.sv
// Shared types and constants for the seal (encrypt + hash) producer pipeline.
// Ports: none (package only).
// Provides the record layout carried through the output FIFO.
package seal_pkg;

  localparam int BYTE_W = 8;
  localparam int SEQ_W  = 8;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [BYTE_W-1:0] enc;
    logic [BYTE_W-1:0] hash;
  } seal_rec_t;

endpackage

// File: rtl/encrypt.sv
// Byte cipher: rotate left by 3, then XOR with a fixed key.
// Ports: din (plaintext byte) -> dout (ciphertext byte).
// Purely combinational, zero latency.
module encrypt
  import seal_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  assign dout = {din[4:0], din[7:5]} ^ 8'h3C;

endmodule

// File: rtl/hash.sv
// Byte hash of the ciphertext: (enc ^ 0xA7) + nibble-swapped enc, mod 256.
// Ports: enc (ciphertext byte) -> h (hash byte).
// Purely combinational, zero latency.
module hash
  import seal_pkg::*;
(
  input  logic [BYTE_W-1:0] enc,
  output logic [BYTE_W-1:0] h
);

  assign h = (enc ^ 8'hA7) + {enc[3:0], enc[7:4]};

endmodule

// File: rtl/seal_fifo.sv
// Synchronous show-ahead FIFO with synchronous clear and async active-low reset.
// Ports: push/din write, pop/dout read head, full/empty/level status, clear flush.
// Push while full and pop while empty are ignored; clear overrides both.
module seal_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra-bit pointers: difference gives occupancy 0..DEPTH without ambiguity.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seal_pipelined.sv
// Producer side of the encrypt/hash link: plaintext in, {seq, enc, hash} records out.
// Ports: in_valid/in_ready/plain in; out_valid/out_ready/out_* records; clear flush; fifo_level.
// Two-cycle latency (stage-1 register then FIFO); in_ready has no path from out_ready.
module seal_pipelined
  import seal_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE_W-1:0]          plain,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W-1:0]          out_enc,
  output logic [BYTE_W-1:0]          out_hash,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(OUT_DEPTH):0] fifo_level
);

  logic              s1_valid;
  logic [BYTE_W-1:0] s1_enc;
  logic [SEQ_W-1:0]  s1_seq;
  logic [SEQ_W-1:0]  seq;
  logic [BYTE_W-1:0] enc_d;
  logic [BYTE_W-1:0] hash_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  seal_rec_t         push_rec;
  seal_rec_t         head;

  encrypt u_encrypt (.din(plain), .dout(enc_d));
  hash    u_hash    (.enc(s1_enc), .h(hash_d));

  // Full check uses the pre-pop state, so stage 1 may drain only into a non-full FIFO.
  assign in_ready = rst_n & ~clear & (~s1_valid | ~fifo_full);
  assign accept   = in_valid & in_ready;
  assign push     = s1_valid & ~fifo_full & ~clear;
  assign pop      = ~fifo_empty & out_ready & ~clear;
  assign push_rec = '{seq: s1_seq, enc: s1_enc, hash: hash_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_enc   <= '0;
      s1_seq   <= '0;
      seq      <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      seq      <= '0;
    end else if (accept) begin
      // Accept implies stage 1 is empty or draining this same edge.
      s1_valid <= 1'b1;
      s1_enc   <= enc_d;
      s1_seq   <= seq;
      seq      <= seq + SEQ_W'(1);
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  seal_fifo #(.T(seal_rec_t), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Record fields are zeroed when nothing is valid (never X from unwritten storage).
  assign out_valid = ~fifo_empty;
  assign out_enc   = out_valid ? head.enc  : '0;
  assign out_hash  = out_valid ? head.hash : '0;
  assign out_seq   = out_valid ? head.seq  : '0;

endmodule

// File: tb/tb_seal_pipelined.sv
module tb_seal_pipelined;
  import seal_pkg::*;

  localparam int DEPTH = 4;

  logic       clk, rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] plain, out_enc, out_hash, out_seq;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  seal_pipelined #(.OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .plain(plain), .out_valid(out_valid), .out_ready(out_ready), .out_enc(out_enc),
    .out_hash(out_hash), .out_seq(out_seq), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cipher and hash from their arithmetic definitions.
  function automatic int enc_f(input int p);
    return (((p << 3) | (p >> 5)) & 255) ^ 8'h3C;
  endfunction
  function automatic int hash_f(input int e);
    return ((e ^ 8'hA7) + (((e << 4) | (e >> 4)) & 255)) & 255;
  endfunction

  // Model: a one-slot staging area feeding a DEPTH-entry queue.
  seal_rec_t stq[$];
  seal_rec_t fq[$];
  int        mseq = 0;

  function automatic bit exp_ready();
    return (rst_n === 1'b1) && !clear && !(stq.size() == 1 && fq.size() == DEPTH);
  endfunction

  always @(negedge rst_n) begin
    stq.delete();
    fq.delete();
    mseq = 0;
  end

  always @(posedge clk) begin : model
    bit        acc;
    int        occ;
    seal_rec_t r;
    if (rst_n === 1'b1) begin
      acc = in_valid && exp_ready();
      if (clear) begin
        stq.delete();
        fq.delete();
        mseq = 0;
      end else begin
        occ = fq.size();
        if (out_ready && occ > 0) void'(fq.pop_front());
        if (stq.size() > 0 && occ < DEPTH) fq.push_back(stq.pop_front());
        if (acc) begin
          r.seq  = 8'(mseq);
          r.enc  = 8'(enc_f(int'(plain)));
          r.hash = 8'(hash_f(int'(r.enc)));
          stq.push_back(r);
          mseq = (mseq + 1) % 256;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_fields", {out_seq, out_enc, out_hash}, 0);
    end else begin
      chk("in_ready", in_ready, exp_ready());
      chk("out_valid", out_valid, fq.size() > 0);
      chk("fifo_level", fifo_level, fq.size());
      if (fq.size() > 0) chk("head_record", {out_seq, out_enc, out_hash}, fq[0]);
    end
  end

  // Pop monitor for literal expectations.
  int         pops = 0;
  int         wraps = 0;
  logic [7:0] last_seq = 0, last_enc = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && !clear && out_valid && out_ready) begin
      if (out_seq == 8'd0 && last_seq == 8'd255) wraps++;
      last_seq = out_seq;
      last_enc = out_enc;
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic r;
    int   n = 0;
    in_valid = 1'b1;
    plain    = b;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("drain", out_valid, 0);
  endtask

  int base, k;
  logic r;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; plain = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_out_valid", out_valid, 0);
    chk("por_level", fifo_level, 0);
    chk("por_in_ready", in_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);

    // Single byte: A5 -> enc 11, hash C7, seq 0.
    out_ready = 1'b1;
    send(8'hA5);
    chk("single_lat_s1", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_seq", out_seq, 8'h00);
    chk("single_enc", out_enc, 8'h11);
    chk("single_hash", out_hash, 8'hC7);
    tick();
    chk("single_gone", out_valid, 0);

    // Streaming 00..0F.
    base = pops;
    for (int i = 0; i < 16; i++) send(8'(i));
    repeat (4) tick();
    chk("stream_count", pops - base, 16);
    chk("stream_last_seq", last_seq, 8'd16);
    chk("stream_last_enc", last_enc, 8'h44);

    // Backpressure: 8 bytes offered, only 5 taken while blocked.
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    plain = 8'h80;
    repeat (8) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        k++;
        plain = 8'(8'h80 + k);
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", k, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_level", fifo_level, 4);
    base = pops;
    out_ready = 1'b1;
    for (int i = k; i < 8; i++) send(8'(8'h80 + i));
    drain();
    chk("bp_count", pops - base, 8);
    chk("bp_last_seq", last_seq, 8'd24);

    // Sequence wrap over 258 records.
    base = pops;
    wraps = 0;
    for (int i = 0; i < 258; i++) send(8'(i));
    drain();
    chk("wrap_count", pops - base, 258);
    chk("wrap_seen", wraps, 1);
    chk("wrap_last_seq", last_seq, 8'd26);

    // Clear with 3 queued and stage 1 busy.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
    chk("clr_pre_level", fifo_level, 3);
    clear = 1'b1; in_valid = 1'b1; plain = 8'h99; out_ready = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_out_shown", out_valid, 1);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_level", fifo_level, 0);
    chk("clr_out_valid", out_valid, 0);
    send(8'h77);
    wait_valid();
    chk("clr_seq", out_seq, 8'd0);
    drain();

    // Asynchronous reset with 3 records queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i));
    tick();
    chk("rst_pre_level", fifo_level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_level", fifo_level, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rst_rel_ready", in_ready, 1);
    out_ready = 1'b1;
    send(8'h33);
    wait_valid();
    chk("rst_seq", out_seq, 8'd0);
    chk("rst_enc", out_enc, 8'hA5);
    chk("rst_hash", out_hash, 8'h5C);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
